// File: rtl/dvp_pattern_tx.sv
// Camera emulator: OV5640-style 8-bit DVP source (vsync/href/data), RGB565 high byte first.
// Generates colour bars, ramp, checker or frame-count frames with sensor-like blanking.
module dvp_pattern_tx #(
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 64,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 8,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_en,
    input  logic [1:0] pattern_sel,
    output logic       cam_vsync,
    output logic       cam_href,
    output logic [7:0] cam_data,
    output logic       busy,
    output logic       frame_done,
    output logic [7:0] frame_cnt
);

    localparam int LT    = 2 * H_ACTIVE + H_BLANK;
    localparam int BW    = $clog2(LT + 1);
    localparam int VA    = (V_SYNC > V_BACK) ? V_SYNC : V_BACK;
    localparam int VB    = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
    localparam int VMAX  = (VA > VB) ? VA : VB;
    localparam int LW    = $clog2(VMAX + 1);
    localparam int BAR_W = H_ACTIVE / 8;
    localparam int PW    = $clog2(BAR_W + 1);

    localparam logic [BW-1:0] BC_LAST = BW'(LT - 1);
    localparam logic [BW-1:0] BC_HREF = BW'(2 * H_ACTIVE);
    localparam logic [PW-1:0] PX_LAST = PW'(BAR_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        VSYNC,
        VBACK,
        ACTIVE,
        VFRONT
    } state_t;

    state_t        state, state_nx;
    logic [BW-1:0] bc;
    logic [LW-1:0] lc;
    logic [LW-1:0] lines_m1;
    logic [2:0]    bar;
    logic [PW-1:0] bar_px;
    logic [1:0]    sel_q;
    logic [7:0]    cnt_q;
    logic          line_end, last_line, frame_end, start;
    logic [15:0]   x, y, pix;
    logic          href_c;
    logic [7:0]    data_c;

    always_comb begin
        lines_m1 = '0;
        case (state)
            VSYNC:   lines_m1 = LW'(V_SYNC - 1);
            VBACK:   lines_m1 = LW'(V_BACK - 1);
            ACTIVE:  lines_m1 = LW'(V_ACTIVE - 1);
            VFRONT:  lines_m1 = LW'(V_FRONT - 1);
            default: lines_m1 = '0;
        endcase
    end

    assign line_end  = (bc == BC_LAST);
    assign last_line = line_end && (lc == lines_m1);
    assign frame_end = (state == VFRONT) && last_line;
    // tx_en only matters when a new frame could begin
    assign start     = tx_en && ((state == IDLE) || frame_end);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (tx_en) state_nx = VSYNC;
            VSYNC:   if (last_line) state_nx = VBACK;
            VBACK:   if (last_line) state_nx = ACTIVE;
            ACTIVE:  if (last_line) state_nx = VFRONT;
            VFRONT:  if (last_line) state_nx = tx_en ? VSYNC : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bc <= '0;
            lc <= '0;
        end else if (state == IDLE) begin
            bc <= '0;
            lc <= '0;
        end else begin
            bc <= line_end ? '0 : bc + 1'b1;
            if (line_end) lc <= last_line ? '0 : lc + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q <= '0;
            cnt_q <= '0;
        end else if (start) begin
            sel_q <= pattern_sel;
            cnt_q <= frame_end ? frame_cnt + 8'd1 : frame_cnt;
        end
    end

    // Bar index advances after the low byte of the last pixel in each bar
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bar    <= '0;
            bar_px <= '0;
        end else if (state != ACTIVE || line_end) begin
            bar    <= '0;
            bar_px <= '0;
        end else if (bc[0]) begin
            if (bar_px == PX_LAST) begin
                bar_px <= '0;
                bar    <= bar + 1'b1;
            end else begin
                bar_px <= bar_px + 1'b1;
            end
        end
    end

    assign x = 16'(bc >> 1);
    assign y = 16'(lc);

    always_comb begin
        pix = 16'h0000;
        case (sel_q)
            2'd0: begin
                case (bar)
                    3'd0:    pix = 16'hFFFF;
                    3'd1:    pix = 16'hFFE0;
                    3'd2:    pix = 16'h07FF;
                    3'd3:    pix = 16'h07E0;
                    3'd4:    pix = 16'hF81F;
                    3'd5:    pix = 16'hF800;
                    3'd6:    pix = 16'h001F;
                    default: pix = 16'h0000;
                endcase
            end
            2'd1:    pix = x;
            2'd2:    pix = (((x ^ y) & 16'h0008) != 16'd0) ? 16'hFFFF : 16'h0000;
            default: pix = {cnt_q, cnt_q};
        endcase
    end

    assign href_c = (state == ACTIVE) && (bc < BC_HREF);
    assign data_c = href_c ? (bc[0] ? pix[7:0] : pix[15:8]) : 8'h00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cam_vsync  <= 1'b0;
            cam_href   <= 1'b0;
            cam_data   <= 8'h00;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= 8'h00;
        end else begin
            cam_vsync  <= (state == VSYNC);
            cam_href   <= href_c;
            cam_data   <= data_c;
            busy       <= (state != IDLE);
            frame_done <= frame_end;
            if (frame_end) frame_cnt <= frame_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_dvp_pattern_tx.sv
// Bench for dvp_pattern_tx: frame-position reference model driven by
// directed and random tx_en / pattern_sel stimulus, small frame geometry.
module tb_dvp_pattern_tx;

    localparam int HA  = 8;
    localparam int HB  = 4;
    localparam int VS  = 1;
    localparam int VBK = 1;
    localparam int VA  = 2;
    localparam int VF  = 1;
    localparam int LT  = 2 * HA + HB;
    localparam int F   = LT * (VS + VBK + VA + VF);

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tx_en;
    logic [1:0] sel;
    logic       cam_vsync;
    logic       cam_href;
    logic [7:0] cam_data;
    logic       busy;
    logic       frame_done;
    logic [7:0] frame_cnt;

    int n_tests;
    int n_fail;
    // ip: frame position being generated inside the DUT, op: position on the pins
    int ip;
    int op;
    int m_fc;
    int m_lat;
    int m_sel;

    dvp_pattern_tx #(
        .H_ACTIVE(HA),
        .H_BLANK (HB),
        .V_SYNC  (VS),
        .V_BACK  (VBK),
        .V_ACTIVE(VA),
        .V_FRONT (VF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_en      (tx_en),
        .pattern_sel(sel),
        .cam_vsync  (cam_vsync),
        .cam_href   (cam_href),
        .cam_data   (cam_data),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] bar_col(input int i);
        case (i)
            0:       return 16'hFFFF;
            1:       return 16'hFFE0;
            2:       return 16'h07FF;
            3:       return 16'h07E0;
            4:       return 16'hF81F;
            5:       return 16'hF800;
            6:       return 16'h001F;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got %0h exp %0h (t=%0t op=%0d)",
                   tag, got, exp, $time, op);
        end
    endtask

    task automatic model_reset();
        ip    = -1;
        op    = -1;
        m_fc  = 0;
        m_lat = 0;
        m_sel = 0;
    endtask

    function automatic bit op_active();
        int line;
        if (op < 0) return 1'b0;
        line = op / LT;
        return (line >= VS + VBK) && (line < VS + VBK + VA) && (op % LT < 2 * HA);
    endfunction

    task automatic check();
        int line, b, x, y;
        logic [15:0] pix;
        logic ev, eh, eb, ed;
        logic [7:0] edata;
        ev = 1'b0; eh = 1'b0; eb = 1'b0; ed = 1'b0; edata = 8'h00;
        pix = 16'h0000;
        if (op >= 0) begin
            eb   = 1'b1;
            line = op / LT;
            b    = op % LT;
            ev   = (line < VS);
            ed   = (op == F - 1);
            if (op_active()) begin
                eh = 1'b1;
                x  = b / 2;
                y  = line - VS - VBK;
                case (m_sel)
                    0:       pix = bar_col(x / (HA / 8));
                    1:       pix = 16'(x);
                    2:       pix = (((x / 8) % 2) != ((y / 8) % 2)) ? 16'hFFFF : 16'h0000;
                    default: pix = {m_lat[7:0], m_lat[7:0]};
                endcase
                edata = (b % 2 == 0) ? pix[15:8] : pix[7:0];
            end
        end
        chk("vsync", 16'(cam_vsync), 16'(ev));
        chk("href", 16'(cam_href), 16'(eh));
        chk("data", 16'(cam_data), 16'(edata));
        chk("busy", 16'(busy), 16'(eb));
        chk("frame_done", 16'(frame_done), 16'(ed));
        chk("frame_cnt", 16'(frame_cnt), 16'(m_fc[7:0]));
    endtask

    task automatic step();
        @(posedge clk);
        op = ip;
        if (op == F - 1) m_fc = (m_fc + 1) % 256;
        if (ip == -1 || ip == F - 1) begin
            if (tx_en) begin
                ip    = 0;
                m_sel = int'(sel);
                m_lat = m_fc;
            end else begin
                ip = -1;
            end
        end else begin
            ip++;
        end
        #1;
        check();
    endtask

    task automatic run_to_active();
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 3 * F && !hit; i++) begin
            step();
            hit = op_active();
        end
        chk("reach_active", 16'(hit), 16'd1);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        tx_en   = 1'b0;
        sel     = 2'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check();
        @(negedge clk);
        rst_n = 1'b1;

        // idle, then colour bars
        repeat (3) step();
        tx_en = 1'b1;
        sel   = 2'd0;
        repeat (F + 10) step();

        // ramp, continuous frames
        sel = 2'd1;
        repeat (2 * F + 20) step();

        // frame-count solid with sel thrashed mid-frame
        sel = 2'd3;
        repeat (F) step();
        for (int i = 0; i < 2 * F; i++) begin
            if (op_active()) sel = 2'($urandom_range(0, 3));
            else sel = 2'd3;
            step();
        end

        // tx_en dropped during ACTIVE, then re-asserted
        run_to_active();
        tx_en = 1'b0;
        repeat (F + 20) step();
        chk("idle_busy", 16'(busy), 16'd0);
        chk("idle_vsync", 16'(cam_vsync), 16'd0);
        tx_en = 1'b1;
        sel   = 2'd2;
        repeat (2) step();
        chk("restart_vsync", 16'(cam_vsync), 16'd1);

        // random run
        for (int i = 0; i < 12 * F; i++) begin
            tx_en = ($urandom_range(0, 15) != 0);
            sel   = 2'($urandom);
            step();
        end

        // reset while in ACTIVE
        tx_en = 1'b1;
        run_to_active();
        rst_n = 1'b0;
        #1;
        chk("rst_vsync", 16'(cam_vsync), 16'd0);
        chk("rst_href", 16'(cam_href), 16'd0);
        chk("rst_data", 16'(cam_data), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_frame_cnt", 16'(frame_cnt), 16'd0);
        model_reset();
        @(posedge clk);
        #1;
        check();
        @(negedge clk);
        rst_n = 1'b1;
        sel   = 2'd2;
        repeat (2 * F + 10) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
